seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the board's common-anode 7-segment display.
//  Drives one shared active-low segment bus and NUM_DIGITS active-low anodes.
//  A ghosting guard blanks the display between digits, and a double-buffered load port
//  means a frame never shows mixed data.
//  The top digit can show the comparator glyph: U when the inputs are equal, L when they differ.
//  Sits between the CORDIC result/check logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS    8       number of digits scanned (2..8)
//  REFRESH_DIV   100000  clk cycles each digit is lit (>=1)
//  BLANK_CYCLES  16      clk cycles all anodes are off before each digit (>=1)
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous reset, active low
//  enable       in   1              1 = scan, 0 = display dark
//  load_valid   in   1              new display image offered
//  load_ready   out  1              image can be accepted (no update pending)
//  load_data    in   4*NUM_DIGITS   hex nibbles; nibble k drives digit k
//  load_dp      in   NUM_DIGITS     decimal point per digit, 1 = lit
//  load_cmp_en  in   1              1 = top digit shows the compare glyph
//  load_cmp_a   in   4              compare operand A
//  load_cmp_b   in   4              compare operand B
//  seg_out      out  8              {a,b,c,d,e,f,g,dp}, active low, registered
//  an_out       out  NUM_DIGITS     anode enables, active low, registered
//  frame_done   out  1              1-cycle pulse after the last digit of each frame
// BEHAVIOUR
//  Reset values: seg_out=8'hFF, an_out=all 1, load_ready=1, frame_done=0.
//   Internal state on reset: display and pending buffers 0, digit idx 0, state IDLE.
//  FSM:
//   IDLE: outputs dark. Leave to BLANK when enable=1.
//   BLANK: an_out all 1, seg_out FF, for BLANK_CYCLES. Then go to SHOW.
//   SHOW: an_out[idx]=0, others 1, for REFRESH_DIV cycles. Then:
//    - idx<NUM_DIGITS-1: idx++, go to BLANK.
//    - idx==NUM_DIGITS-1: idx=0, pulse frame_done, go to BLANK.
//  Registered outputs: seg_out/an_out change on the clk edge that enters each state.
//   Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
//  enable=0 in any state: go to IDLE on the next edge, idx=0, outputs dark.
//   Any pending image is kept; frame_done is not pulsed.
//  Load handshake:
//   - Transfer when load_valid & load_ready: all load_* inputs go into the pending buffer.
//   - load_ready drops to 0 on the next edge.
//   - On the frame_done edge, if an update is pending: pending copies to display and
//     load_ready returns to 1.
//   - An image accepted on the frame_done edge itself is applied at the next frame end.
//   - Display contents never change mid-frame.
//  Digit pattern from the display buffer:
//   hex 0..F = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (dp bit=1).
//   dp bit forced 0 when that digit's dp flag is 1.
//  Compare glyph: when cmp_en=1, digit NUM_DIGITS-1 shows
//   8'b1000_0011 (U) if cmp_a==cmp_b, else 8'b1110_0011 (L).
//   The glyph ignores dp and nibble NUM_DIGITS-1.
//  Counter widths: sized by $clog2 of the parameters; no wrap other than idx at NUM_DIGITS-1.
//  rst_n low mid-frame: all outputs take their reset values immediately, without a clk edge.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 unless stated)
//  1. Reset, then enable=1 with no load. Required: BLANK 2 cycles (an=F, seg=FF), then an=E, seg=03
//     for 4 cycles, then digits 1..3 the same way. frame_done pulses every 24 cycles.
//  2. Load data=16'h1A2F, dp=4'b0010, cmp_en=0 mid-frame. Required: load_ready=0 until frame end.
//     Next frame: digit0=71, digit1=24 (dp lit), digit2=11, digit3=9F. No change before the boundary.
//  3. Load cmp_en=1, a=5, b=5. Required: digit3 seg=83.
//     Then load a=5, b=6. Required: digit3 seg=E3 from the following frame.
//  4. load_valid held high on the frame_done edge, then a second image offered while
//     load_ready=0. Required: the first image is shown one frame later; the second is not
//     accepted until load_ready=1.
//  5. enable dropped while digit 2 is lit. Required: next edge an=F, seg=FF, no frame_done.
//     Re-enable: the scan restarts at BLANK, digit 0.
//  6. rst_n pulsed low mid-SHOW with an update pending. Required: an/seg dark asynchronously,
//     load_ready=1, buffers 0. After release with enable=1, digits show 03.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display image load handshake for the 7-segment scan controller
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                      load_valid;
   logic                      load_ready;
   logic [4*NUM_DIGITS-1:0]   load_data;
   logic [NUM_DIGITS-1:0]     load_dp;
   logic                      load_cmp_en;
   logic [3:0]                load_cmp_a;
   logic [3:0]                load_cmp_b;

   modport master (
      output load_valid, load_data, load_dp, load_cmp_en, load_cmp_a, load_cmp_b,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_data, load_dp, load_cmp_en, load_cmp_a, load_cmp_b,
      output load_ready
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed common-anode 7-segment scan controller
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   seven_seg_scan_ctrl_if.slave  load,
   output logic [7:0]            seg_out,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic                  frame_done
);
   localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   logic [1:0]              state;
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic                    ready;

   logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
   logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
   logic                    pend_cmp_en, disp_cmp_en;
   logic [3:0]              pend_a, pend_b, disp_a, disp_b;

   logic [3:0]              nib;
   logic [7:0]              seg_pat;
   logic [NUM_DIGITS-1:0]   an_pat;
   logic                    frame_end;

   assign load.load_ready = ready;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'h03;  4'h1: hex_seg = 8'h9F;
         4'h2: hex_seg = 8'h25;  4'h3: hex_seg = 8'h0D;
         4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h49;
         4'h6: hex_seg = 8'h41;  4'h7: hex_seg = 8'h1F;
         4'h8: hex_seg = 8'h01;  4'h9: hex_seg = 8'h09;
         4'hA: hex_seg = 8'h11;  4'hB: hex_seg = 8'hC1;
         4'hC: hex_seg = 8'h63;  4'hD: hex_seg = 8'h85;
         4'hE: hex_seg = 8'h61;  default: hex_seg = 8'h71;
      endcase
   endfunction

   // Pattern for the digit about to be lit; the glyph overrides both nibble and dp on the top digit.
   always_comb begin
      nib     = disp_data[idx*4 +: 4];
      seg_pat = hex_seg(nib);
      if (disp_dp[idx])
         seg_pat[0] = 1'b0;
      if (disp_cmp_en && idx == IDX_LAST)
         seg_pat = (disp_a == disp_b) ? 8'b1000_0011 : 8'b1110_0011;
      an_pat    = ~(NUM_DIGITS'(1) << idx);
      frame_end = enable && state == ST_SHOW && cnt == SHOW_LAST && idx == IDX_LAST;
   end

   // Scan FSM: blank gap, then lit digit; outputs registered on the edge entering each state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         idx        <= '0;
         seg_out    <= 8'hFF;
         an_out     <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!enable) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            seg_out <= 8'hFF;
            an_out  <= '1;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_BLANK;
                  cnt   <= '0;
               end
               ST_BLANK: begin
                  if (cnt == BLANK_LAST) begin
                     state   <= ST_SHOW;
                     cnt     <= '0;
                     seg_out <= seg_pat;
                     an_out  <= an_pat;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_SHOW: begin
                  if (cnt == SHOW_LAST) begin
                     state   <= ST_BLANK;
                     cnt     <= '0;
                     seg_out <= 8'hFF;
                     an_out  <= '1;
                     if (idx == IDX_LAST) begin
                        idx        <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

   // Double buffer: accept into pending, promote to display only at a frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready       <= 1'b1;
         pend_data   <= '0;
         pend_dp     <= '0;
         pend_cmp_en <= 1'b0;
         pend_a      <= '0;
         pend_b      <= '0;
         disp_data   <= '0;
         disp_dp     <= '0;
         disp_cmp_en <= 1'b0;
         disp_a      <= '0;
         disp_b      <= '0;
      end else if (frame_end && !ready) begin
         disp_data   <= pend_data;
         disp_dp     <= pend_dp;
         disp_cmp_en <= pend_cmp_en;
         disp_a      <= pend_a;
         disp_b      <= pend_b;
         ready       <= 1'b1;
      end else if (load.load_valid && ready) begin
         pend_data   <= load.load_data;
         pend_dp     <= load.load_dp;
         pend_cmp_en <= load.load_cmp_en;
         pend_a      <= load.load_cmp_a;
         pend_b      <= load.load_cmp_b;
         ready       <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed-vector bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] seg_out;
   logic [3:0] an_out;
   logic       frame_done;

   int tests_run    = 0;
   int tests_failed = 0;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) lif();

   seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (lif.slave),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after the frame_done edge.
   task automatic wait_frame();
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!frame_done) check("frame_timeout", 32'd0, 32'd1);
   endtask

   // Called at the frame_done negedge plus 'used' cycles; samples each digit mid-SHOW.
   task automatic sample_digits(input int used, output logic [31:0] s);
      logic [3:0] an_exp;
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? 3 - used : 6) @(negedge clk);
         an_exp = ~(4'b0001 << k);
         check("an_digit", {28'd0, an_out}, {28'd0, an_exp});
         s[8*k +: 8] = seg_out;
      end
   endtask

   task automatic load_img(input logic [15:0] d, input logic [3:0] dp, input logic ce,
                           input logic [3:0] a, input logic [3:0] b);
      lif.load_data   = d;
      lif.load_dp     = dp;
      lif.load_cmp_en = ce;
      lif.load_cmp_a  = a;
      lif.load_cmp_b  = b;
      lif.load_valid  = 1'b1;
      @(negedge clk);
      lif.load_valid  = 1'b0;
   endtask

   initial begin
      logic [31:0] s;
      logic [3:0]  an_tab [7];
      logic [7:0]  seg_tab [7];
      int          n;

      an_tab  = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF};
      seg_tab = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF};
      rst_n = 1'b0;
      enable = 1'b0;
      lif.load_valid = 1'b0;
      lif.load_data = '0;
      lif.load_dp = '0;
      lif.load_cmp_en = 1'b0;
      lif.load_cmp_a = '0;
      lif.load_cmp_b = '0;

      // 1: reset values, first-digit timing, frame period
      repeat (2) @(negedge clk);
      check("rst_seg", {24'd0, seg_out}, 32'hFF);
      check("rst_an", {28'd0, an_out}, 32'hF);
      check("rst_ready", {31'd0, lif.load_ready}, 32'd1);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("t1_an", {28'd0, an_out}, {28'd0, an_tab[i]});
         check("t1_seg", {24'd0, seg_out}, {24'd0, seg_tab[i]});
      end
      wait_frame();
      check("t1_fd_blank_an", {28'd0, an_out}, 32'hF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 100);
      check("t1_frame_period", n, 32'd24);
      @(negedge clk);
      check("t1_fd_one_cycle", {31'd0, frame_done}, 32'd0);

      // 2: load mid-frame, no change before boundary
      wait_frame();
      load_img(16'h1A2F, 4'b0010, 1'b0, 4'h0, 4'h0);
      check("t2_ready_low", {31'd0, lif.load_ready}, 32'd0);
      sample_digits(1, s);
      check("t2_old_frame", s, 32'h03030303);
      check("t2_ready_still_low", {31'd0, lif.load_ready}, 32'd0);
      wait_frame();
      check("t2_ready_back", {31'd0, lif.load_ready}, 32'd1);
      sample_digits(0, s);
      check("t2_new_frame", s, 32'h9F112471);

      // 3: compare glyph equal then different
      wait_frame();
      load_img(16'h1A2F, 4'b0010, 1'b1, 4'h5, 4'h5);
      sample_digits(1, s);
      check("t3_before_glyph", s, 32'h9F112471);
      wait_frame();
      load_img(16'h1A2F, 4'b0010, 1'b1, 4'h5, 4'h6);
      sample_digits(1, s);
      check("t3_glyph_u", s, 32'h83112471);
      wait_frame();
      sample_digits(0, s);
      check("t3_glyph_l", s, 32'hE3112471);

      // 4: load on the frame_done edge, second image blocked while pending
      repeat (2) @(negedge clk);
      lif.load_data = 16'h3210;
      lif.load_dp = 4'b0000;
      lif.load_cmp_en = 1'b0;
      lif.load_valid = 1'b1;
      @(negedge clk);
      check("t4_fd_edge", {31'd0, frame_done}, 32'd1);
      check("t4_accepted_on_fd", {31'd0, lif.load_ready}, 32'd0);
      lif.load_data = 16'hBEEF;
      sample_digits(1, s);
      check("t4_still_old", s, 32'hE3112471);
      check("t4_second_blocked", {31'd0, lif.load_ready}, 32'd0);
      wait_frame();
      check("t4_ready_at_fd", {31'd0, lif.load_ready}, 32'd1);
      @(negedge clk);
      check("t4_second_accepted", {31'd0, lif.load_ready}, 32'd0);
      lif.load_valid = 1'b0;
      sample_digits(1, s);
      check("t4_first_image", s, 32'h0D259F03);
      wait_frame();
      sample_digits(0, s);
      check("t4_second_image", s, 32'hC1616171);

      // 5: enable dropped while digit 2 lit
      wait_frame();
      repeat (15) @(negedge clk);
      check("t5_digit2_lit", {28'd0, an_out}, 32'hB);
      enable = 1'b0;
      @(negedge clk);
      check("t5_dark_an", {28'd0, an_out}, 32'hF);
      check("t5_dark_seg", {24'd0, seg_out}, 32'hFF);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (frame_done) n++;
         @(negedge clk);
      end
      check("t5_no_frame_done", n, 32'd0);
      enable = 1'b1;
      @(negedge clk);
      check("t5_restart_blank", {28'd0, an_out}, 32'hF);
      repeat (2) @(negedge clk);
      check("t5_restart_an", {28'd0, an_out}, 32'hE);
      check("t5_restart_seg", {24'd0, seg_out}, 32'h71);

      // 6: async reset mid-SHOW with update pending
      load_img(16'h5555, 4'b1111, 1'b0, 4'h0, 4'h0);
      check("t6_pending", {31'd0, lif.load_ready}, 32'd0);
      check("t6_still_show", {28'd0, an_out}, 32'hE);
      rst_n = 1'b0;
      #1;
      check("t6_async_an", {28'd0, an_out}, 32'hF);
      check("t6_async_seg", {24'd0, seg_out}, 32'hFF);
      check("t6_async_ready", {31'd0, lif.load_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_frame();
      check("t6_ready_after", {31'd0, lif.load_ready}, 32'd1);
      sample_digits(0, s);
      check("t6_buffers_zero", s, 32'h03030303);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
